// File: rtl/pe_group_conv4.sv
//------------------------------------------------------------------------------
// pe_group_conv4 : 4x4 row-stationary PE group, one 4-tap 1-D conv pass per block
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module pe_group_conv4 #(
  parameter int DataWidth         = 32,
  parameter int BufferWidth       = 2,
  parameter int BufferSize        = 4,
  parameter int W_PEGroupSize     = 4,
  parameter int O_PEGroupSize     = 4,
  parameter int I_PEGroupSize     = 7,
  parameter int W_PEAddrWidth     = 2,
  parameter int O_PEAddrWidth     = 2,
  parameter int I_PEAddrWidth     = 3,
  parameter int I_BlockCount      = 4,
  parameter int I_BlockCountWidth = 2
) (
  input  logic                     clk,
  input  logic                     aclr,
  input  logic                     W_DataInValid,
  output logic                     W_DataInRdy,
  input  logic [DataWidth-1:0]     W_DataIn,
  input  logic                     I_DataInValid,
  output logic                     I_DataInRdy,
  input  logic [DataWidth-1:0]     I_DataIn,
  input  logic                     O_DataInValid,
  output logic                     O_DataInRdy,
  input  logic [DataWidth-1:0]     O_DataIn,
  output logic                     O_DataOutValid,
  input  logic                     O_DataOutRdy,
  output logic [DataWidth-1:0]     O_DataOut,
  output logic [DataWidth-1:0]     Test_I_Data00,
  output logic [DataWidth-1:0]     Test_I_Data10,
  output logic [DataWidth-1:0]     Test_I_Data20,
  output logic [DataWidth-1:0]     Test_I_Data30,
  output logic [DataWidth-1:0]     Test_I_Data31,
  output logic [DataWidth-1:0]     Test_I_Data32,
  output logic [DataWidth-1:0]     Test_I_Data33,
  output logic [I_PEAddrWidth-1:0] Test_I_PEAddr
);

  typedef enum logic [1:0] {
    ST_LOAD_W  = 2'd0,
    ST_LOAD    = 2'd1,
    ST_COMPUTE = 2'd2
  } state_e;

  state_e                     state_q;
  logic [DataWidth-1:0]       w_q   [W_PEGroupSize];
  logic [DataWidth-1:0]       d_q   [I_PEGroupSize];
  logic [DataWidth-1:0]       p_q   [O_PEGroupSize];
  logic [DataWidth-1:0]       buf_q [BufferSize];
  logic [DataWidth-1:0]       res_d [O_PEGroupSize];
  logic [W_PEAddrWidth-1:0]   w_addr_q;
  logic [I_PEAddrWidth-1:0]   i_addr_q;
  logic [O_PEAddrWidth-1:0]   o_addr_q;
  logic                       i_full_q;
  logic                       o_full_q;
  logic [I_BlockCountWidth-1:0] blk_q;
  logic [BufferWidth-1:0]     rd_ptr_q;
  logic [BufferWidth:0]       cnt_q;

  logic w_fire, i_fire, o_fire, out_fire;
  logic w_last, i_last, o_last, i_done, o_done;

  assign W_DataInRdy    = (state_q == ST_LOAD_W);
  assign I_DataInRdy    = (state_q == ST_LOAD) && !i_full_q;
  assign O_DataInRdy    = (state_q == ST_LOAD) && !o_full_q;
  assign O_DataOutValid = (cnt_q != '0);
  assign O_DataOut      = O_DataOutValid ? buf_q[rd_ptr_q] : '0;

  assign w_fire   = W_DataInValid && W_DataInRdy;
  assign i_fire   = I_DataInValid && I_DataInRdy;
  assign o_fire   = O_DataInValid && O_DataInRdy;
  assign out_fire = O_DataOutValid && O_DataOutRdy;

  assign w_last = w_fire && (w_addr_q == W_PEAddrWidth'(W_PEGroupSize - 1));
  assign i_last = i_fire && (i_addr_q == I_PEAddrWidth'(I_PEGroupSize - 1));
  assign o_last = o_fire && (o_addr_q == O_PEAddrWidth'(O_PEGroupSize - 1));
  // Counting the word accepted this edge lets COMPUTE follow the last transfer directly.
  assign i_done = i_full_q || i_last;
  assign o_done = o_full_q || o_last;

  assign Test_I_Data00 = d_q[0];
  assign Test_I_Data10 = d_q[1];
  assign Test_I_Data20 = d_q[2];
  assign Test_I_Data30 = d_q[3];
  assign Test_I_Data31 = d_q[4];
  assign Test_I_Data32 = d_q[5];
  assign Test_I_Data33 = d_q[6];
  assign Test_I_PEAddr = i_addr_q;

  // PE(r,c) multiplies row weight r by diagonal r+c; column sums start from the psum.
  always_comb begin
    for (int c = 0; c < O_PEGroupSize; c++) begin
      res_d[c] = p_q[c];
      for (int r = 0; r < W_PEGroupSize; r++) begin
        res_d[c] = res_d[c] + w_q[r] * d_q[r + c];
      end
    end
  end

  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      state_q  <= ST_LOAD_W;
      w_addr_q <= '0;
      i_addr_q <= '0;
      o_addr_q <= '0;
      i_full_q <= 1'b0;
      o_full_q <= 1'b0;
      blk_q    <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int k = 0; k < W_PEGroupSize; k++) w_q[k]   <= '0;
      for (int k = 0; k < I_PEGroupSize; k++) d_q[k]   <= '0;
      for (int k = 0; k < O_PEGroupSize; k++) p_q[k]   <= '0;
      for (int k = 0; k < BufferSize; k++)    buf_q[k] <= '0;
    end else begin
      if (out_fire) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        cnt_q    <= cnt_q - 1'b1;
      end
      case (state_q)
        ST_LOAD_W: begin
          if (w_fire) begin
            w_q[w_addr_q] <= W_DataIn;
            if (w_last) begin
              w_addr_q <= '0;
              blk_q    <= '0;
              state_q  <= ST_LOAD;
            end else begin
              w_addr_q <= w_addr_q + 1'b1;
            end
          end
        end
        ST_LOAD: begin
          if (i_fire) begin
            d_q[i_addr_q] <= I_DataIn;
            if (i_last) begin
              i_addr_q <= '0;
              i_full_q <= 1'b1;
            end else begin
              i_addr_q <= i_addr_q + 1'b1;
            end
          end
          if (o_fire) begin
            p_q[o_addr_q] <= O_DataIn;
            if (o_last) begin
              o_addr_q <= '0;
              o_full_q <= 1'b1;
            end else begin
              o_addr_q <= o_addr_q + 1'b1;
            end
          end
          if (i_done && o_done && (cnt_q == '0)) state_q <= ST_COMPUTE;
        end
        ST_COMPUTE: begin
          // Buffer is empty here, so the whole result set lands starting at the head.
          for (int c = 0; c < O_PEGroupSize; c++) begin
            buf_q[rd_ptr_q + BufferWidth'(c)] <= res_d[c];
          end
          cnt_q    <= (BufferWidth + 1)'(O_PEGroupSize);
          i_full_q <= 1'b0;
          o_full_q <= 1'b0;
          blk_q    <= blk_q + 1'b1;
          if (blk_q == I_BlockCountWidth'(I_BlockCount - 1)) state_q <= ST_LOAD_W;
          else                                               state_q <= ST_LOAD;
        end
        default: state_q <= ST_LOAD_W;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pe_group_conv4.sv
//------------------------------------------------------------------------------
// tb_pe_group_conv4 : directed self-checking bench for pe_group_conv4
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_pe_group_conv4;

  logic        clk;
  logic        aclr;
  logic        W_DataInValid, W_DataInRdy;
  logic [31:0] W_DataIn;
  logic        I_DataInValid, I_DataInRdy;
  logic [31:0] I_DataIn;
  logic        O_DataInValid, O_DataInRdy;
  logic [31:0] O_DataIn;
  logic        O_DataOutValid, O_DataOutRdy;
  logic [31:0] O_DataOut;
  logic [31:0] Test_I_Data00, Test_I_Data10, Test_I_Data20, Test_I_Data30;
  logic [31:0] Test_I_Data31, Test_I_Data32, Test_I_Data33;
  logic [2:0]  Test_I_PEAddr;

  int n_cmp;
  int n_bad;

  pe_group_conv4 u_dut (
    .clk            (clk),
    .aclr           (aclr),
    .W_DataInValid  (W_DataInValid),
    .W_DataInRdy    (W_DataInRdy),
    .W_DataIn       (W_DataIn),
    .I_DataInValid  (I_DataInValid),
    .I_DataInRdy    (I_DataInRdy),
    .I_DataIn       (I_DataIn),
    .O_DataInValid  (O_DataInValid),
    .O_DataInRdy    (O_DataInRdy),
    .O_DataIn       (O_DataIn),
    .O_DataOutValid (O_DataOutValid),
    .O_DataOutRdy   (O_DataOutRdy),
    .O_DataOut      (O_DataOut),
    .Test_I_Data00  (Test_I_Data00),
    .Test_I_Data10  (Test_I_Data10),
    .Test_I_Data20  (Test_I_Data20),
    .Test_I_Data30  (Test_I_Data30),
    .Test_I_Data31  (Test_I_Data31),
    .Test_I_Data32  (Test_I_Data32),
    .Test_I_Data33  (Test_I_Data33),
    .Test_I_PEAddr  (Test_I_PEAddr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // s: 0 = weight, 1 = input, 2 = psum
  task automatic send(input int s, input logic [31:0] v);
    logic r;
    int   n;
    n = 0;
    case (s)
      0:       begin W_DataIn = v; W_DataInValid = 1'b1; end
      1:       begin I_DataIn = v; I_DataInValid = 1'b1; end
      default: begin O_DataIn = v; O_DataInValid = 1'b1; end
    endcase
    forever begin
      r = (s == 0) ? W_DataInRdy : (s == 1) ? I_DataInRdy : O_DataInRdy;
      @(posedge clk);
      if (r) break;
      #1;
      n++;
      if (n > 50) begin
        chk("send_rdy", {31'b0, r}, 32'd1);
        break;
      end
    end
    #1;
    W_DataInValid = 1'b0;
    I_DataInValid = 1'b0;
    O_DataInValid = 1'b0;
  endtask

  task automatic recv(input string tag, input logic [31:0] exp);
    int n;
    n = 0;
    while (!O_DataOutValid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!O_DataOutValid) chk({tag, "_valid"}, {31'b0, O_DataOutValid}, 32'd1);
    chk(tag, O_DataOut, exp);
    @(posedge clk); #1;
  endtask

  task automatic load_w(input logic [31:0] a, b, c, d);
    send(0, a); send(0, b); send(0, c); send(0, d);
  endtask

  task automatic load_p(input logic [31:0] a, b, c, d);
    send(2, a); send(2, b); send(2, c); send(2, d);
  endtask

  initial begin
    int cnt;
    logic r;
    n_cmp = 0;
    n_bad = 0;
    aclr = 1'b0;
    W_DataInValid = 1'b0; I_DataInValid = 1'b0; O_DataInValid = 1'b0;
    W_DataIn = '0; I_DataIn = '0; O_DataIn = '0;
    O_DataOutRdy = 1'b1;
    #1;
    chk("rst_wrdy",  {31'b0, W_DataInRdy}, 32'd1);
    chk("rst_irdy",  {31'b0, I_DataInRdy}, 32'd0);
    chk("rst_ordy",  {31'b0, O_DataInRdy}, 32'd0);
    chk("rst_valid", {31'b0, O_DataOutValid}, 32'd0);
    chk("rst_dout",  O_DataOut, 32'd0);
    chk("rst_addr",  {29'b0, Test_I_PEAddr}, 32'd0);
    @(negedge clk); aclr = 1'b1;
    @(posedge clk); #1;

    // Pass 1 (block 0): basic
    load_w(1, 2, 3, 4);
    chk("p1_wrdy_off", {31'b0, W_DataInRdy}, 32'd0);
    for (int k = 0; k < 7; k++) send(1, 32'(k + 1));
    load_p(100, 0, 0, 0);
    chk("p1_compute_novalid", {31'b0, O_DataOutValid}, 32'd0);
    @(posedge clk); #1;
    chk("p1_latency_valid", {31'b0, O_DataOutValid}, 32'd1);
    chk("d00", Test_I_Data00, 32'd1);
    chk("d10", Test_I_Data10, 32'd2);
    chk("d20", Test_I_Data20, 32'd3);
    chk("d30", Test_I_Data30, 32'd4);
    chk("d31", Test_I_Data31, 32'd5);
    chk("d32", Test_I_Data32, 32'd6);
    chk("d33", Test_I_Data33, 32'd7);
    recv("p1_out0", 32'd130);
    recv("p1_out1", 32'd40);
    recv("p1_out2", 32'd50);
    recv("p1_out3", 32'd60);

    // Pass 2 (block 1): continuous input stream, then backpressure
    O_DataOutRdy = 1'b0;
    cnt = 0;
    I_DataInValid = 1'b1;
    for (int cyc = 0; cyc < 10; cyc++) begin
      I_DataIn = 32'(cnt + 2);
      r = I_DataInRdy;
      if (r) chk("stream_addr", {29'b0, Test_I_PEAddr}, 32'(cnt));
      @(posedge clk); #1;
      if (r) cnt++;
    end
    I_DataInValid = 1'b0;
    chk("stream_count", 32'(cnt), 32'd7);
    chk("stream_irdy", {31'b0, I_DataInRdy}, 32'd0);
    chk("stream_addr_wrap", {29'b0, Test_I_PEAddr}, 32'd0);
    chk("stream_d00", Test_I_Data00, 32'd2);
    chk("stream_d33", Test_I_Data33, 32'd8);
    load_p(5, 6, 7, 8);
    repeat (4) @(posedge clk);
    #1;
    chk("bp_valid", {31'b0, O_DataOutValid}, 32'd1);
    chk("bp_head", O_DataOut, 32'd45);

    // Pass 3 (block 2): loads while buffer is full, must not compute
    for (int k = 0; k < 7; k++) send(1, 32'(k + 1));
    load_p(0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("bp_hold_head", O_DataOut, 32'd45);
    chk("bp_ordy_off", {31'b0, O_DataInRdy}, 32'd0);
    chk("bp_irdy_off", {31'b0, I_DataInRdy}, 32'd0);
    O_DataOutRdy = 1'b1;
    recv("p2_out0", 32'd45);
    recv("p2_out1", 32'd56);
    recv("p2_out2", 32'd67);
    recv("p2_out3", 32'd78);
    recv("p3_out0", 32'd30);
    recv("p3_out1", 32'd40);
    recv("p3_out2", 32'd50);
    recv("p3_out3", 32'd60);

    // Pass 4 (block 3): last pass of the weight load
    for (int k = 0; k < 7; k++) send(1, 32'd1);
    load_p(0, 0, 0, 0);
    chk("blk_compute_wrdy", {31'b0, W_DataInRdy}, 32'd0);
    @(posedge clk); #1;
    chk("blk_wrdy", {31'b0, W_DataInRdy}, 32'd1);
    chk("blk_irdy", {31'b0, I_DataInRdy}, 32'd0);
    for (int k = 0; k < 4; k++) recv("p4_out", 32'd10);

    // Overflow: wraps modulo 2^32
    load_w(32'hFFFF_FFFF, 0, 0, 0);
    for (int k = 0; k < 7; k++) send(1, (k == 0) ? 32'd2 : 32'd0);
    load_p(0, 0, 0, 0);
    recv("ovf_out0", 32'hFFFF_FFFE);
    recv("ovf_out1", 32'd0);
    recv("ovf_out2", 32'd0);
    recv("ovf_out3", 32'd0);

    // Asynchronous reset mid-pass after 3 inputs
    send(1, 32'd5); send(1, 32'd6); send(1, 32'd7);
    chk("pre_rst_d20", Test_I_Data20, 32'd7);
    #3 aclr = 1'b0;
    #1;
    chk("mid_rst_wrdy",  {31'b0, W_DataInRdy}, 32'd1);
    chk("mid_rst_irdy",  {31'b0, I_DataInRdy}, 32'd0);
    chk("mid_rst_ordy",  {31'b0, O_DataInRdy}, 32'd0);
    chk("mid_rst_valid", {31'b0, O_DataOutValid}, 32'd0);
    chk("mid_rst_dout",  O_DataOut, 32'd0);
    chk("mid_rst_addr",  {29'b0, Test_I_PEAddr}, 32'd0);
    chk("mid_rst_d00",   Test_I_Data00, 32'd0);
    chk("mid_rst_d20",   Test_I_Data20, 32'd0);
    @(negedge clk); aclr = 1'b1;
    @(posedge clk); #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
